// File: rtl/coherence_ctrl.sv
// rtl/coherence_ctrl.sv - two-cache bus arbiter with snoop-forced writeback ahead of reads
module coherence_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [ADDR_W-1:0] daddr0,
  input  logic [ADDR_W-1:0] daddr1,
  input  logic [DATA_W-1:0] dstore0,
  input  logic [DATA_W-1:0] dstore1,
  input  logic [1:0]        ccdirty,
  output logic [1:0]        dwait,
  output logic [DATA_W-1:0] dload0,
  output logic [DATA_W-1:0] dload1,
  output logic [1:0]        ccwait,
  output logic [1:0]        ccwrite,
  output logic [ADDR_W-1:0] ccsnoopaddr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [3:0] {
    IDLE, WB1, WB2, SNOOP, SWB1, SWB2, RD1, RD2, DONE
  } state_t;

  state_t state, state_n;
  logic   g, g_n, prio, prio_n;
  logic   o;
  logic   g_sel;
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr_g, addr_o;
  logic [DATA_W-1:0] data_g, data_o;

  // granted/other cache views of the request buses
  assign o      = ~g;
  assign req    = dREN | dWEN;
  assign addr_g = g ? daddr1  : daddr0;
  assign addr_o = g ? daddr0  : daddr1;
  assign data_g = g ? dstore1 : dstore0;
  assign data_o = g ? dstore0 : dstore1;

  // grant candidate in IDLE: priority breaks ties, a lone requester wins outright
  always_comb begin
    g_sel = g;
    if (req == 2'b11)      g_sel = prio;
    else if (req == 2'b10) g_sel = 1'b1;
    else if (req == 2'b01) g_sel = 1'b0;
  end

  // state, grant and priority registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      g     <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      g     <= g_n;
      prio  <= prio_n;
    end
  end

  // next-state and bus outputs; the non-granted cache always sees dwait high
  always_comb begin
    state_n     = state;
    g_n         = g;
    prio_n      = prio;
    dwait       = 2'b11;
    dload0      = '0;
    dload1      = '0;
    ccwait      = 2'b00;
    ccwrite     = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        g_n = g_sel;
        if (dWEN[g_sel])      state_n = WB1;
        else if (dREN[g_sel]) state_n = SNOOP;
      end
      WB1, WB2: begin
        ramWEN   = 1'b1;
        ramaddr  = addr_g;
        ramstore = data_g;
        if (ram_ready) begin
          dwait[g] = 1'b0;
          state_n  = (state == WB1) ? WB2 : DONE;
        end
      end
      SNOOP: begin
        ccwait[o]   = 1'b1;
        ccsnoopaddr = addr_g;
        if (dREN[o] | dWEN[o]) begin
          // other cache is mid-transaction: back off and let it go first
          state_n = IDLE;
          prio_n  = o;
        end else if (ccdirty[o]) begin
          state_n = SWB1;
        end else begin
          state_n = RD1;
        end
      end
      SWB1, SWB2: begin
        ccwait[o]   = 1'b1;
        ccwrite[o]  = 1'b1;
        ccsnoopaddr = addr_g;
        if (dWEN[o]) begin
          ramWEN   = 1'b1;
          ramaddr  = addr_o;
          ramstore = data_o;
          if (ram_ready) begin
            dwait[o] = 1'b0;
            state_n  = (state == SWB1) ? SWB2 : RD1;
          end
        end
      end
      RD1, RD2: begin
        ccwait[o] = 1'b1;
        ramREN    = 1'b1;
        ramaddr   = addr_g;
        if (g) dload1 = ramload;
        else   dload0 = ramload;
        if (ram_ready) begin
          dwait[g] = 1'b0;
          state_n  = (state == RD1) ? RD2 : DONE;
        end
      end
      DONE: begin
        prio_n  = o;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// tb/tb_coherence_ctrl.sv - directed cycle-by-cycle bench for coherence_ctrl
module tb_coherence_ctrl;

  logic        CLK;
  logic        RST;
  logic [1:0]  dREN, dWEN, ccdirty;
  logic [31:0] daddr0, daddr1, dstore0, dstore1;
  logic [1:0]  dwait, ccwait, ccwrite;
  logic [31:0] dload0, dload1, ccsnoopaddr, ramaddr, ramstore, ramload;
  logic        ramREN, ramWEN, ram_ready;

  int compared   = 0;
  int mismatched = 0;

  coherence_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN),
    .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
    .ccdirty(ccdirty), .dwait(dwait), .dload0(dload0), .dload1(dload1),
    .ccwait(ccwait), .ccwrite(ccwrite), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic got, input logic exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to the next cycle; inputs change 2 time units after the edge
  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; dREN = 2'b00; dWEN = 2'b00; ccdirty = 2'b00;
    daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0;
    ramload = 32'hDEAD_BEEF; ram_ready = 1'b1;

    // reset state
    nxt(); #1;
    chk2("rst_dwait", dwait, 2'b11);
    chk2("rst_ccwait", ccwait, 2'b00);
    chk2("rst_ccwrite", ccwrite, 2'b00);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk32("rst_dload0", dload0, 32'h0);
    chk32("rst_ramaddr", ramaddr, 32'h0);
    chk32("rst_snoopaddr", ccsnoopaddr, 32'h0);
    RST = 1'b0;

    // single read on cache 0
    dREN = 2'b01; daddr0 = 32'h100; ramload = 32'hAAAA_0000; #1;
    chk2("t1_idle_dwait", dwait, 2'b11);
    chk1("t1_idle_ramREN", ramREN, 1'b0);
    nxt(); #1;
    chk2("t1_snoop_ccwait", ccwait, 2'b10);
    chk32("t1_snoop_addr", ccsnoopaddr, 32'h100);
    chk1("t1_snoop_ramREN", ramREN, 1'b0);
    nxt(); #1;
    chk1("t1_rd1_ramREN", ramREN, 1'b1);
    chk32("t1_rd1_ramaddr", ramaddr, 32'h100);
    chk2("t1_rd1_dwait", dwait, 2'b10);
    chk32("t1_rd1_dload0", dload0, 32'hAAAA_0000);
    chk2("t1_rd1_ccwait", ccwait, 2'b10);
    nxt(); daddr0 = 32'h104; ramload = 32'hAAAA_0004; #1;
    chk32("t1_rd2_ramaddr", ramaddr, 32'h104);
    chk2("t1_rd2_dwait", dwait, 2'b10);
    chk32("t1_rd2_dload0", dload0, 32'hAAAA_0004);
    chk32("t1_rd2_dload1", dload1, 32'h0);
    nxt(); dREN = 2'b00; #1;
    chk2("t1_done_ccwait", ccwait, 2'b00);
    chk1("t1_done_ramREN", ramREN, 1'b0);
    chk2("t1_done_dwait", dwait, 2'b11);

    // prio is now 1: simultaneous request grants cache 1
    nxt(); dREN = 2'b11; daddr0 = 32'h300; daddr1 = 32'h400; #1;
    chk2("t2a_idle_dwait", dwait, 2'b11);
    nxt(); dREN = 2'b10; #1;
    chk2("t2a_snoop_ccwait", ccwait, 2'b01);
    chk32("t2a_snoop_addr", ccsnoopaddr, 32'h400);
    nxt(); ramload = 32'hBBBB_0000; #1;
    chk32("t2a_rd1_ramaddr", ramaddr, 32'h400);
    chk2("t2a_rd1_dwait", dwait, 2'b01);
    chk32("t2a_rd1_dload1", dload1, 32'hBBBB_0000);
    chk32("t2a_rd1_dload0", dload0, 32'h0);

    // reset pulse during RD2
    nxt(); daddr1 = 32'h404; RST = 1'b1; #1;
    chk32("rstmid_rd2_ramaddr", ramaddr, 32'h404);
    nxt(); RST = 1'b0; dREN = 2'b11; daddr0 = 32'h500; daddr1 = 32'h600; #1;
    chk2("rstmid_dwait", dwait, 2'b11);
    chk1("rstmid_ramREN", ramREN, 1'b0);
    chk2("rstmid_ccwait", ccwait, 2'b00);
    chk32("rstmid_ramaddr", ramaddr, 32'h0);
    chk32("rstmid_dload1", dload1, 32'h0);

    // simultaneous after reset: cache 0 first, then cache 1
    nxt(); dREN = 2'b01; #1;
    chk2("t2_c0_snoop_ccwait", ccwait, 2'b10);
    chk32("t2_c0_snoop_addr", ccsnoopaddr, 32'h500);
    nxt(); #1;
    chk32("t2_c0_rd1_ramaddr", ramaddr, 32'h500);
    chk2("t2_c0_rd1_dwait", dwait, 2'b10);
    nxt(); daddr0 = 32'h504; #1;
    chk32("t2_c0_rd2_ramaddr", ramaddr, 32'h504);
    nxt(); dREN = 2'b10; #1;
    chk2("t2_c0_done_ccwait", ccwait, 2'b00);
    nxt(); #1;
    chk2("t2_c1_idle_dwait", dwait, 2'b11);
    nxt(); #1;
    chk2("t2_c1_snoop_ccwait", ccwait, 2'b01);
    chk32("t2_c1_snoop_addr", ccsnoopaddr, 32'h600);
    nxt(); #1;
    chk32("t2_c1_rd1_ramaddr", ramaddr, 32'h600);
    chk2("t2_c1_rd1_dwait", dwait, 2'b01);
    chk2("t2_c1_rd1_ccwait", ccwait, 2'b01);
    nxt(); daddr1 = 32'h604; #1;
    chk32("t2_c1_rd2_ramaddr", ramaddr, 32'h604);
    nxt(); dREN = 2'b00; #1;
    chk2("t2_c1_done_ccwait", ccwait, 2'b00);

    // dirty snoop: cache 1 reads 0x200, cache 0 holds it dirty
    nxt(); dREN = 2'b10; daddr1 = 32'h200; daddr0 = 32'h700; dstore0 = 32'hD0; #1;
    chk2("t3_idle_dwait", dwait, 2'b11);
    nxt(); ccdirty = 2'b01; #1;
    chk2("t3_snoop_ccwait", ccwait, 2'b01);
    chk32("t3_snoop_addr", ccsnoopaddr, 32'h200);
    chk2("t3_snoop_ccwrite", ccwrite, 2'b00);
    nxt(); #1;
    chk2("t3_swb1_hold_ccwrite", ccwrite, 2'b01);
    chk1("t3_swb1_hold_ramWEN", ramWEN, 1'b0);
    chk1("t3_swb1_hold_ramREN", ramREN, 1'b0);
    nxt(); dWEN = 2'b01; #1;
    chk1("t3_swb1_ramWEN", ramWEN, 1'b1);
    chk32("t3_swb1_ramaddr", ramaddr, 32'h700);
    chk32("t3_swb1_ramstore", ramstore, 32'hD0);
    chk2("t3_swb1_dwait", dwait, 2'b10);
    nxt(); daddr0 = 32'h704; dstore0 = 32'hD4; #1;
    chk32("t3_swb2_ramaddr", ramaddr, 32'h704);
    chk32("t3_swb2_ramstore", ramstore, 32'hD4);
    chk2("t3_swb2_ccwrite", ccwrite, 2'b01);
    chk2("t3_swb2_dwait", dwait, 2'b10);
    nxt(); dWEN = 2'b00; ccdirty = 2'b00; #1;
    chk1("t3_rd1_ramREN", ramREN, 1'b1);
    chk32("t3_rd1_ramaddr", ramaddr, 32'h200);
    chk2("t3_rd1_dwait", dwait, 2'b01);
    chk2("t3_rd1_ccwrite", ccwrite, 2'b00);
    nxt(); daddr1 = 32'h204; #1;
    chk32("t3_rd2_ramaddr", ramaddr, 32'h204);
    nxt(); dREN = 2'b00; #1;
    chk1("t3_done_ramREN", ramREN, 1'b0);

    // yield: cache 0 read granted while cache 1 is writing back
    nxt(); dREN = 2'b01; daddr0 = 32'h800; dWEN = 2'b10; daddr1 = 32'h900; dstore1 = 32'hE0; #1;
    chk2("t4_idle_dwait", dwait, 2'b11);
    nxt(); #1;
    chk2("t4_snoop_ccwait", ccwait, 2'b10);
    chk1("t4_snoop_ramWEN", ramWEN, 1'b0);
    chk1("t4_snoop_ramREN", ramREN, 1'b0);
    nxt(); #1;
    chk1("t4_idle2_ramWEN", ramWEN, 1'b0);
    chk2("t4_idle2_dwait", dwait, 2'b11);
    nxt(); #1;
    chk1("t4_wb1_ramWEN", ramWEN, 1'b1);
    chk32("t4_wb1_ramaddr", ramaddr, 32'h900);
    chk32("t4_wb1_ramstore", ramstore, 32'hE0);
    chk2("t4_wb1_dwait", dwait, 2'b01);
    nxt(); daddr1 = 32'h904; dstore1 = 32'hE4; #1;
    chk32("t4_wb2_ramaddr", ramaddr, 32'h904);
    chk32("t4_wb2_ramstore", ramstore, 32'hE4);
    chk2("t4_wb2_dwait", dwait, 2'b01);
    nxt(); dWEN = 2'b00; #1;
    chk1("t4_done_ramWEN", ramWEN, 1'b0);
    nxt(); #1;
    chk2("t4_c0_idle_dwait", dwait, 2'b11);
    nxt(); #1;
    chk32("t4_c0_snoop_addr", ccsnoopaddr, 32'h800);
    nxt(); #1;
    chk32("t4_c0_rd1_ramaddr", ramaddr, 32'h800);
    chk2("t4_c0_rd1_dwait", dwait, 2'b10);
    nxt(); #1;
    chk2("t4_c0_rd2_dwait", dwait, 2'b10);
    nxt(); dREN = 2'b00; #1;
    chk2("t4_c0_done_ccwait", ccwait, 2'b00);

    // writeback with 3 stall cycles per word: 10 cycles IDLE..DONE
    nxt(); dWEN = 2'b01; daddr0 = 32'hA00; dstore0 = 32'hF0; ram_ready = 1'b0; #1;
    chk1("t5_idle_ramWEN", ramWEN, 1'b0);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 3; k++) begin
        nxt(); ram_ready = 1'b0;
        if (w == 1) begin daddr0 = 32'hA04; dstore0 = 32'hF4; end
        #1;
        chk1("t5_stall_ramWEN", ramWEN, 1'b1);
        chk2("t5_stall_dwait", dwait, 2'b11);
        chk32("t5_stall_ramaddr", ramaddr, (w == 1) ? 32'hA04 : 32'hA00);
      end
      nxt(); ram_ready = 1'b1; #1;
      chk1("t5_ready_ramWEN", ramWEN, 1'b1);
      chk2("t5_ready_dwait", dwait, 2'b10);
      chk32("t5_ready_ramstore", ramstore, (w == 1) ? 32'hF4 : 32'hF0);
    end
    nxt(); dWEN = 2'b00; #1;
    chk1("t5_done_ramWEN", ramWEN, 1'b0);
    chk2("t5_done_dwait", dwait, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/coherence_ctrl.md
Name: coherence_ctrl

Overview:
- Bus/coherence controller that sits directly downstream of the two per-core dcache control units, and upstream of the single RAM port.
- Arbitrates dREN/dWEN block transactions (2 words each) from cache 0 and cache 1, and drives dwait/dload back to the caches.
- Snoops the non-granted cache on every read miss. It uses ccwait/ccwrite to force a dirty copy to write back before the requester's read is served.

Parameters:
ADDR_W, 32, address width of daddr/ramaddr/ccsnoopaddr
DATA_W, 32, data word width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset, synchronous, active-high
dREN  in  2  per-cache read request (bit i = cache i)
dWEN  in  2  per-cache write(back) request
daddr0, daddr1  in  ADDR_W  per-cache request address
dstore0, dstore1  in  DATA_W  per-cache write data
ccdirty  in  2  snooped cache i holds ccsnoopaddr dirty (combinational response)
dwait  out  2  per-cache stall; low for exactly the cycle a word completes
dload0, dload1  out  DATA_W  read data to cache i (ramload when serving i, else 0)
ccwait  out  2  snoop hold on cache i
ccwrite  out  2  write-back demand to snooped cache i
ccsnoopaddr  out  ADDR_W  address being snooped
ramREN, ramWEN  out  1  RAM strobes
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ram_ready  in  1  RAM completes current word this cycle

Behaviour:
- Reset (RST=1 at edge): state=IDLE, prio=0 (cache 0 favoured), g=0.
- Reset outputs: dwait=2'b11, ccwait=0, ccwrite=0, ramREN=ramWEN=0, dload*=0, ccsnoopaddr=0, ramaddr=ramstore=0.
- RST asserted mid-transaction aborts immediately to IDLE; no RAM strobes are issued the following cycle.
- Defaults in every state: dwait=2'b11; all other outputs 0 unless listed below.
- g = granted cache; o = other cache (~g).
- IDLE:
  - Requester set r = dREN|dWEN.
  - If both caches request, g = prio; if one requests, g = that cache.
  - Next state: dWEN[g] -> WB1 (dWEN wins if dREN[g] is also high); else dREN[g] -> SNOOP; else stay in IDLE.
- WB1/WB2:
  - Drive ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - When ram_ready: dwait[g]=0 and advance (WB1->WB2, WB2->DONE).
- SNOOP (exactly 1 cycle minimum):
  - Drive ccwait[o]=1, ccsnoopaddr=daddr[g].
  - If dREN[o]|dWEN[o] (o is mid-transaction): yield. Go to IDLE and set prio=o, so o is served next.
  - Else if ccdirty[o]: go to SWB1.
  - Else: go to RD1.
- SWB1/SWB2:
  - Drive ccwait[o]=1, ccwrite[o]=1, ccsnoopaddr=daddr[g].
  - While dWEN[o]=0, hold state with no RAM strobes.
  - When dWEN[o]=1: ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o]. On ram_ready: dwait[o]=0 and advance (SWB1->SWB2, SWB2->RD1).
- RD1/RD2:
  - Drive ccwait[o]=1, ramREN=1, ramaddr=daddr[g], dload[g]=ramload.
  - On ram_ready: dwait[g]=0 and advance (RD1->RD2, RD2->DONE).
- DONE: single cycle with all outputs at defaults (ccwait dropped so the snooped cache leaves WAIT). prio<=o; next state IDLE.
- Latency:
  - Minimum read: IDLE, SNOOP, RD1, RD2, DONE = 5 cycles with ram_ready constantly high.
  - Minimum writeback: IDLE, WB1, WB2, DONE = 4 cycles.
- The word sequence is whatever daddr[g] the cache presents per word; the controller does no address arithmetic.
- The non-granted cache always sees dwait high, so a simultaneous request is never lost: it is held until its grant.
- ram_ready while not in WB/SWB/RD is ignored.

Test Plan:
- Single read, cache 0, ram_ready=1, ccdirty=0:
  - Required response: ramREN for 2 cycles at daddr0 values 0x100 and 0x104.
  - dwait[0]=0 in both of those cycles; dload0=ramload.
  - ccwait[1]=1 from SNOOP through RD2, then 0 in DONE; prio=1 afterwards.
- Simultaneous dREN=2'b11 after reset: cache 0 served first; cache 1 served next, with ccwait[0] asserted during cache 1's SNOOP/RD.
- Dirty snoop:
  - Stimulus: cache 1 dREN at 0x200; ccdirty[0]=1; cache 0 raises dWEN one cycle after ccwrite[0].
  - Required: two RAM writes at daddr0, then two RAM reads at 0x200.
  - ccwrite[0]=1 throughout SWB1/SWB2.
- Yield:
  - Stimulus: cache 0 dREN granted; cache 1 dWEN already high in the SNOOP cycle.
  - Required: FSM returns to IDLE with no RAM strobe in that cycle, then cache 1 writeback executes first.
- RAM stalls: ram_ready low 3 cycles per word on a writeback -> ramWEN held steady, dwait[g] low only on the ready cycles, total 10 cycles.
- RST pulsed during RD2 -> next cycle all outputs at reset values; a subsequent request on cache 1 is arbitrated with prio=0.
